bitvec_index_encoder: RTL and testbench



---
 rtl/bitvec_enc_pkg.sv | 24 ++
 rtl/bitvec_index_encoder_prio_sel.sv | 29 ++
 rtl/bitvec_index_encoder.sv | 136 +++++++++++++
 tb/tb_bitvec_index_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitvec_enc_pkg.sv
// Shared types and helpers for the bit-vector index encoder: FSM state,
// index-width calculation and the popcount used by the optional pending counter.
package bitvec_enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Sized for the widest legal vector; callers zero-extend narrower inputs.
  function automatic logic [8:0] popcount(input logic [255:0] vec);
    logic [8:0] cnt;
    cnt = 9'd0;
    for (int i = 0; i < 256; i++) begin
      cnt = cnt + {8'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bitvec_index_encoder_prio_sel.sv
// prio_sel: combinational first-set-bit finder returning index, one-hot mask
// and a found flag; MSB_FIRST picks the highest instead of the lowest set bit.
module prio_sel
  import bitvec_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_found
);

  // Scan so the winning bit is visited last and overwrites earlier candidates.
  always_comb begin
    o_idx   = {IDX_W{1'b0}};
    o_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j       = MSB_FIRST ? i : (WIDTH - 1 - i);
      o_idx   = i_vec[j] ? IDX_W'(j) : o_idx;
      o_found = o_found | i_vec[j];
    end
    o_onehot = o_found ? ({{(WIDTH-1){1'b0}}, 1'b1} << o_idx) : {WIDTH{1'b0}};
  end

endmodule

// File: rtl/bitvec_index_encoder.sv
// Multi-hot vector to index-stream encoder with valid/ready on both sides.
// Optional pending-count output enabled by defining BITVEC_ENC_PENDING_CNT_EN.
module bitvec_index_encoder
  import bitvec_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_vec
`ifdef BITVEC_ENC_PENDING_CNT_EN
  ,
  output logic [IDX_W:0]   pending_cnt
`endif
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_next;
  logic [WIDTH-1:0] w_cur_mask;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;
  logic             r_zero_vec;
  logic             w_accept;
  logic             w_beat;
  logic [IDX_W-1:0] w_sel_idx;
  logic [WIDTH-1:0] w_sel_onehot;
  logic             w_sel_found;
  logic             w_sel_last;

  // Selection runs on next-cycle pending so index/last can be registered.
  prio_sel #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_sel (
    .i_vec    (w_pending_next),
    .o_idx    (w_sel_idx),
    .o_onehot (w_sel_onehot),
    .o_found  (w_sel_found)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: leave DRAIN only on the last beat unless a non-zero vector refills.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = (w_accept && (|in_vec)) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (w_beat && r_out_last) begin
          w_state_next = (w_accept && (|in_vec)) ? ST_DRAIN : ST_IDLE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; in_ready may follow out_ready combinationally on the last beat.
  always_comb begin
    out_valid = (r_state == ST_DRAIN);
    in_ready  = (r_state == ST_IDLE) || (out_valid && out_ready && r_out_last);
    w_accept  = in_valid && in_ready;
    w_beat    = out_valid && out_ready;
  end

  // Pending update: load on accept, otherwise clear the index just delivered.
  always_comb begin
    w_cur_mask = {{(WIDTH-1){1'b0}}, 1'b1} << r_out_idx;
    if (w_accept) begin
      w_pending_next = in_vec;
    end else if (w_beat) begin
      w_pending_next = r_pending & ~w_cur_mask;
    end else begin
      w_pending_next = r_pending;
    end
    w_sel_last = w_sel_found && (w_pending_next == w_sel_onehot);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= {WIDTH{1'b0}};
      r_out_idx  <= {IDX_W{1'b0}};
      r_out_last <= 1'b0;
      r_zero_vec <= 1'b0;
    end else begin
      r_pending  <= w_pending_next;
      r_out_idx  <= w_sel_idx;
      r_out_last <= w_sel_last;
      r_zero_vec <= w_accept && !(|in_vec);
    end
  end

  assign out_idx  = r_out_idx;
  assign out_last = r_out_last;
  assign zero_vec = r_zero_vec;

`ifdef BITVEC_ENC_PENDING_CNT_EN
  logic [IDX_W:0] r_pending_cnt;

  // Remaining-index counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending_cnt <= {(IDX_W+1){1'b0}};
    end else if (w_accept) begin
      r_pending_cnt <= (IDX_W+1)'(popcount(256'(in_vec)));
    end else if (w_beat) begin
      r_pending_cnt <= r_pending_cnt - {{IDX_W{1'b0}}, 1'b1};
    end else begin
      r_pending_cnt <= r_pending_cnt;
    end
  end

  assign pending_cnt = r_pending_cnt;
`endif

endmodule

// File: tb/tb_bitvec_index_encoder.sv
// Bench for bitvec_index_encoder: three instances (8/LSB, 8/MSB, 12/LSB) share
// stimulus and are checked every cycle against a per-instance index-list model.
module tb_bitvec_index_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] vec;

  always #5 clk = ~clk;

  logic       rdy0, rdy1, rdy2, v0, v1, v2, l0, l1, l2, z0, z1, z2;
  logic [2:0] idx0, idx1;
  logic [3:0] idx2;

  logic       dv [3];
  logic       dr [3];
  logic       dl [3];
  logic       dz [3];
  logic [3:0] di [3];

  bitvec_index_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_vec(vec[7:0]),
    .out_valid(v0), .out_ready(out_ready), .out_idx(idx0), .out_last(l0), .zero_vec(z0)
`ifdef BITVEC_ENC_PENDING_CNT_EN
    , .pending_cnt(pc0)
`endif
  );

  bitvec_index_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_vec(vec[7:0]),
    .out_valid(v1), .out_ready(out_ready), .out_idx(idx1), .out_last(l1), .zero_vec(z1)
`ifdef BITVEC_ENC_PENDING_CNT_EN
    , .pending_cnt(pc1)
`endif
  );

  bitvec_index_encoder #(.WIDTH(12), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_vec(vec),
    .out_valid(v2), .out_ready(out_ready), .out_idx(idx2), .out_last(l2), .zero_vec(z2)
`ifdef BITVEC_ENC_PENDING_CNT_EN
    , .pending_cnt(pc2)
`endif
  );

`ifdef BITVEC_ENC_PENDING_CNT_EN
  logic [3:0] pc0, pc1;
  logic [4:0] pc2;
  logic [4:0] dc [3];
  assign dc[0] = {1'b0, pc0};
  assign dc[1] = {1'b0, pc1};
  assign dc[2] = pc2;
`endif

  assign dv[0] = v0;   assign dv[1] = v1;   assign dv[2] = v2;
  assign dr[0] = rdy0; assign dr[1] = rdy1; assign dr[2] = rdy2;
  assign dl[0] = l0;   assign dl[1] = l1;   assign dl[2] = l2;
  assign dz[0] = z0;   assign dz[1] = z1;   assign dz[2] = z2;
  assign di[0] = {1'b0, idx0};
  assign di[1] = {1'b0, idx1};
  assign di[2] = idx2;

  // Model: list of indices still to be emitted for the current vector.
  int mw   [3] = '{8, 8, 12};
  bit mmsb [3] = '{1'b0, 1'b1, 1'b0};
  int mlist [3][16];
  int mhead [3];
  int mcnt  [3];
  bit mzero [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mhead[k] = 0;
      mcnt[k]  = 0;
      mzero[k] = 1'b0;
    end
  endtask

  // One cycle: drive inputs, compare every instance, advance the model past the edge.
  task automatic step(input bit iv, input logic [11:0] ivec, input bit ordy);
    bit ev, er, acc, bt;
    int b;
    @(negedge clk);
    in_valid  = iv;
    vec       = ivec;
    out_ready = ordy;
    #1;
    for (int k = 0; k < 3; k++) begin
      ev = (mcnt[k] > 0);
      er = (mcnt[k] == 0) || (mcnt[k] == 1 && ordy);
      chk("out_valid", k, int'(dv[k]), int'(ev));
      chk("in_ready", k, int'(dr[k]), int'(er));
      chk("zero_vec", k, int'(dz[k]), int'(mzero[k]));
      if (ev) begin
        chk("out_idx", k, int'(di[k]), mlist[k][mhead[k]]);
        chk("out_last", k, int'(dl[k]), int'(mcnt[k] == 1));
      end
`ifdef BITVEC_ENC_PENDING_CNT_EN
      chk("pending_cnt", k, int'(dc[k]), mcnt[k]);
`endif
      acc = iv && er;
      bt  = ev && ordy;
      if (bt) begin
        mhead[k]++;
        mcnt[k]--;
      end
      mzero[k] = 1'b0;
      if (acc) begin
        mhead[k] = 0;
        mcnt[k]  = 0;
        for (int n = 0; n < mw[k]; n++) begin
          b = mmsb[k] ? (mw[k] - 1 - n) : n;
          if (ivec[b]) begin
            mlist[k][mcnt[k]] = b;
            mcnt[k]++;
          end
        end
        mzero[k] = (mcnt[k] == 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rv;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vec       = 12'h000;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, int'(dv[k]), 0);
      chk("rst_idx", k, int'(di[k]), 0);
      chk("rst_last", k, int'(dl[k]), 0);
      chk("rst_zero", k, int'(dz[k]), 0);
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("rst_ready", k, int'(dr[k]), 1);

    // 0xA4 with continuous out_ready: LSB order 2,5,7 and MSB order 7,5,2
    step(1'b1, 12'h0A4, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    chk("a4_idx_a", 0, int'(di[0]), 2);
    chk("a4_last_a", 0, int'(dl[0]), 0);
    chk("a4_idx_b", 1, int'(di[1]), 7);
    step(1'b0, 12'h000, 1'b1);
    chk("a4_idx_b", 0, int'(di[0]), 5);
    step(1'b0, 12'h000, 1'b1);
    chk("a4_idx_c", 0, int'(di[0]), 7);
    chk("a4_last_c", 0, int'(dl[0]), 1);
    chk("a4_ready_c", 0, int'(dr[0]), 1);
    chk("a4_msb_end", 1, int'(di[1]), 2);
    step(1'b0, 12'h000, 1'b1);

    // MSB-first stall: held at 7 for three stalled cycles, then 5, 2
    step(1'b1, 12'h0A4, 1'b1);
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 12'h000, 1'b0);
      chk("stall_hold", 1, int'(di[1]), 7);
      chk("stall_last", 1, int'(dl[1]), 0);
    end
    step(1'b0, 12'h000, 1'b1);
    chk("stall_rel", 1, int'(di[1]), 7);
    step(1'b0, 12'h000, 1'b1);
    chk("stall_5", 1, int'(di[1]), 5);
    step(1'b0, 12'h000, 1'b1);
    chk("stall_2", 1, int'(di[1]), 2);
    chk("stall_2_last", 1, int'(dl[1]), 1);
    step(1'b0, 12'h000, 1'b1);

    // Back-to-back 0x01 then 0x80, no bubble
    step(1'b1, 12'h001, 1'b1);
    step(1'b1, 12'h080, 1'b1);
    chk("b2b_idx0", 0, int'(di[0]), 0);
    chk("b2b_last0", 0, int'(dl[0]), 1);
    chk("b2b_ready", 0, int'(dr[0]), 1);
    step(1'b0, 12'h000, 1'b1);
    chk("b2b_valid7", 0, int'(dv[0]), 1);
    chk("b2b_idx7", 0, int'(di[0]), 7);
    chk("b2b_last7", 0, int'(dl[0]), 1);
    step(1'b0, 12'h000, 1'b1);

    // Zero vector: single zero_vec pulse, nothing emitted
    step(1'b1, 12'h000, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    chk("zero_pulse", 0, int'(dz[0]), 1);
    chk("zero_novalid", 0, int'(dv[0]), 0);
    chk("zero_ready", 0, int'(dr[0]), 1);
    step(1'b0, 12'h000, 1'b1);
    chk("zero_once", 0, int'(dz[0]), 0);

    // Full 12-bit vector on the non-power-of-two instance
    step(1'b1, 12'hFFF, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 12'h000, 1'b1);
      chk("full_idx", 2, int'(di[2]), i);
      chk("full_last", 2, int'(dl[2]), int'(i == 11));
`ifdef BITVEC_ENC_PENDING_CNT_EN
      chk("full_cnt", 2, int'(dc[2]), 12 - i);
`endif
    end
    step(1'b0, 12'h000, 1'b1);
    chk("full_done", 2, int'(dv[2]), 0);

    // Asynchronous reset in the middle of a drain
    step(1'b1, 12'h0FF, 1'b1);
    repeat (3) step(1'b0, 12'h000, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("mid_rst_valid", k, int'(dv[k]), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 12'h000, 1'b1);

    // Randomised traffic
    repeat (3000) begin
      case ($urandom_range(0, 9))
        0:       rv = 12'h000;
        1:       rv = 12'd1 << $urandom_range(0, 11);
        2:       rv = 12'hFFF;
        default: rv = 12'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, rv, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
